// File: rtl/sec_dncnt.sv
// BCD mm:ss countdown timer (59:59 .. 00:00) with start/stop, borrow pulse and timed alarm.
// Optional build macro SEC_DNCNT_AUTORELOAD_EN: reload the preset at expiry and keep counting.
module sec_dncnt #(
  parameter int ALARM_TICKS = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       SS,
  input  logic       LOAD,
  input  logic [3:0] PSL,
  input  logic [2:0] PSH,
  input  logic [3:0] PML,
  input  logic [2:0] PMH,
  output logic [3:0] SL,
  output logic [2:0] SH,
  output logic [3:0] ML,
  output logic [2:0] MH,
  output logic       RUN,
  output logic       ALARM,
  output logic       BR
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [7:0] TICK_LIMIT = 8'(ALARM_TICKS);

  state_t     state_q;
  logic [7:0] tick_q;
  logic [7:0] tick_inc;
  logic       tick_last;

  logic [3:0] p_sl, p_ml;
  logic [2:0] p_sh, p_mh;
  logic [3:0] d_sl, d_ml;
  logic [2:0] d_sh, d_mh;
  logic       count_zero, count_one;

  logic [3:0] r_sl, r_ml;
  logic [2:0] r_sh, r_mh;
  logic       use_reload;

  always_comb begin
    p_sl = (PSL > 4'd9) ? 4'd9 : PSL;
    p_sh = (PSH > 3'd5) ? 3'd5 : PSH;
    p_ml = (PML > 4'd9) ? 4'd9 : PML;
    p_mh = (PMH > 3'd5) ? 3'd5 : PMH;
  end

  // One-second decrement with borrow rippling SL -> SH -> ML -> MH.
  always_comb begin
    d_sl = (SL == 4'd0) ? 4'd9 : SL - 4'd1;
    d_sh = SH;
    d_ml = ML;
    d_mh = MH;
    if (SL == 4'd0) begin
      d_sh = (SH == 3'd0) ? 3'd5 : SH - 3'd1;
      if (SH == 3'd0) begin
        d_ml = (ML == 4'd0) ? 4'd9 : ML - 4'd1;
        if (ML == 4'd0) d_mh = MH - 3'd1;
      end
    end
  end

  assign count_zero = (MH == 3'd0) && (ML == 4'd0) && (SH == 3'd0) && (SL == 4'd0);
  assign count_one  = (MH == 3'd0) && (ML == 4'd0) && (SH == 3'd0) && (SL == 4'd1);
  assign BR         = (state_q == S_RUN) && EN && count_one && !SS && !LOAD;
  assign tick_inc   = tick_q + 8'd1;
  assign tick_last  = (tick_inc == TICK_LIMIT);

`ifdef SEC_DNCNT_AUTORELOAD_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sl <= '0;
      r_sh <= '0;
      r_ml <= '0;
      r_mh <= '0;
    end else if (LOAD) begin
      r_sl <= p_sl;
      r_sh <= p_sh;
      r_ml <= p_ml;
      r_mh <= p_mh;
    end
  end
  // A 00:00 reload value falls back to the plain expire-to-DONE behaviour.
  assign use_reload = (r_sl != 4'd0) || (r_sh != 3'd0) || (r_ml != 4'd0) || (r_mh != 3'd0);
`else
  assign r_sl       = '0;
  assign r_sh       = '0;
  assign r_ml       = '0;
  assign r_mh       = '0;
  assign use_reload = 1'b0;
`endif

  // NOTE: all state updates use non-blocking assignments so every register samples
  // pre-edge values; blocking here would make branch order change the hardware.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      SL      <= '0;
      SH      <= '0;
      ML      <= '0;
      MH      <= '0;
      RUN     <= 1'b0;
      ALARM   <= 1'b0;
    end else if (LOAD) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      SL      <= p_sl;
      SH      <= p_sh;
      ML      <= p_ml;
      MH      <= p_mh;
      RUN     <= 1'b0;
      ALARM   <= 1'b0;
    end else if (SS) begin
      unique case (state_q)
        S_IDLE: if (!count_zero) begin
          state_q <= S_RUN;
          RUN     <= 1'b1;
        end
        S_RUN: begin
          state_q <= S_PAUSE;
          RUN     <= 1'b0;
        end
        S_PAUSE: begin
          state_q <= S_RUN;
          RUN     <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ALARM   <= 1'b0;
          tick_q  <= '0;
        end
      endcase
    end else if (EN) begin
      if (BR) begin
        ALARM  <= 1'b1;
        tick_q <= '0;
        SL     <= r_sl;
        SH     <= r_sh;
        ML     <= r_ml;
        MH     <= r_mh;
        if (!use_reload) begin
          state_q <= S_DONE;
          RUN     <= 1'b0;
        end
      end else begin
        if (state_q == S_RUN) begin
          SL <= d_sl;
          SH <= d_sh;
          ML <= d_ml;
          MH <= d_mh;
        end
        // Alarm ticks are counted on EN while the alarm sounds, whatever the count is doing.
        if (ALARM) begin
          if (tick_last) begin
            ALARM  <= 1'b0;
            tick_q <= '0;
            if (state_q == S_DONE) state_q <= S_IDLE;
          end else begin
            tick_q <= tick_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sec_dncnt.sv
// Directed bench for sec_dncnt: the driver queues hand-computed expectations per cycle,
// a monitor pops and compares them on the falling edge.
module tb_sec_dncnt;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0, SS = 1'b0, LOAD = 1'b0;
  logic [3:0] PSL = '0, PML = '0;
  logic [2:0] PSH = '0, PMH = '0;
  logic [3:0] SL, ML;
  logic [2:0] SH, MH;
  logic       RUN, ALARM, BR;

  sec_dncnt #(.ALARM_TICKS(10)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .SS(SS), .LOAD(LOAD),
    .PSL(PSL), .PSH(PSH), .PML(PML), .PMH(PMH),
    .SL(SL), .SH(SH), .ML(ML), .MH(MH),
    .RUN(RUN), .ALARM(ALARM), .BR(BR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [15:0] cnt;
    logic        run;
    logic        alarm;
    logic        br;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   drv_done = 1'b0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, " count"}, {1'b0, MH, ML, 1'b0, SH, SL}, e.cnt);
        check({e.tag, " run"},   {15'd0, RUN},   {15'd0, e.run});
        check({e.tag, " alarm"}, {15'd0, ALARM}, {15'd0, e.alarm});
        check({e.tag, " br"},    {15'd0, BR},    {15'd0, e.br});
      end
    end
  end

  // Drive one cycle of inputs; expected values are the outputs seen during that cycle.
  task automatic step(input string tag, input logic r, en, ss, ld,
                      input logic [15:0] cnt, input logic run, al, br);
    exp_t e;
    RST = r; EN = en; SS = ss; LOAD = ld;
    e.tag = tag; e.cnt = cnt; e.run = run; e.alarm = al; e.br = br;
    exp_q.push_back(e);
    @(posedge CLK); #1;
    RST = 1'b0; EN = 1'b0; SS = 1'b0; LOAD = 1'b0;
  endtask

  task automatic preset(input logic [2:0] mh, input logic [3:0] ml,
                        input logic [2:0] sh, input logic [3:0] sl);
    PMH = mh; PML = ml; PSH = sh; PSL = sl;
  endtask

  initial begin
    @(posedge CLK); #1;
    step("reset", 1, 0, 0, 0, 16'h0000, 0, 0, 0);

    // Reset mid-run at 03:27
    preset(0, 3, 2, 7);
    step("ld0327", 0, 0, 0, 1, 16'h0000, 0, 0, 0);
    step("ss0327", 0, 0, 1, 0, 16'h0327, 0, 0, 0);
    step("run0327", 0, 0, 0, 0, 16'h0327, 1, 0, 0);
    step("rst_mid", 1, 0, 0, 0, 16'h0000, 0, 0, 0);
    step("post_rst_en", 0, 1, 0, 0, 16'h0000, 0, 0, 0);
    step("post_rst", 0, 0, 0, 0, 16'h0000, 0, 0, 0);

`ifdef SEC_DNCNT_AUTORELOAD_EN
    preset(0, 0, 0, 2);
    step("ld0002", 0, 0, 0, 1, 16'h0000, 0, 0, 0);
    step("ss0002", 0, 0, 1, 0, 16'h0002, 0, 0, 0);
    step("en0002", 0, 1, 0, 0, 16'h0002, 1, 0, 0);
    step("br0001", 0, 1, 0, 0, 16'h0001, 1, 0, 1);
    step("reload", 0, 0, 0, 0, 16'h0002, 1, 1, 0);
    step("rl_en", 0, 1, 0, 0, 16'h0002, 1, 1, 0);
    step("rl_cnt", 0, 0, 0, 0, 16'h0001, 1, 1, 0);
    preset(0, 0, 0, 0);
    step("rl_ld", 0, 0, 0, 1, 16'h0001, 1, 1, 0);
    step("rl_clr", 0, 0, 0, 0, 16'h0000, 0, 0, 0);
`else
    // 00:03 expiry and alarm duration
    preset(0, 0, 0, 3);
    step("ld0003", 0, 0, 0, 1, 16'h0000, 0, 0, 0);
    step("ss0003", 0, 0, 1, 0, 16'h0003, 0, 0, 0);
    step("en0003", 0, 1, 0, 0, 16'h0003, 1, 0, 0);
    step("en0002", 0, 1, 0, 0, 16'h0002, 1, 0, 0);
    step("br0001", 0, 1, 0, 0, 16'h0001, 1, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      step($sformatf("done_en%0d", k), 0, 1, 0, 0, 16'h0000, 0, 1, 0);
      if (k < 10) step($sformatf("done_gap%0d", k), 0, 0, 0, 0, 16'h0000, 0, 1, 0);
    end
    step("alarm_off", 0, 0, 0, 0, 16'h0000, 0, 0, 0);
`endif

    // Borrow through all digits
    preset(1, 0, 0, 0);
    step("ld1000", 0, 0, 0, 1, 16'h0000, 0, 0, 0);
    step("ss1000", 0, 0, 1, 0, 16'h1000, 0, 0, 0);
    step("en1000", 0, 1, 0, 0, 16'h1000, 1, 0, 0);
    step("dec0959", 0, 0, 0, 0, 16'h0959, 1, 0, 0);
    preset(0, 1, 0, 0);
    step("ld0100", 0, 0, 0, 1, 16'h0959, 1, 0, 0);
    step("ss0100", 0, 0, 1, 0, 16'h0100, 0, 0, 0);
    step("en0100", 0, 1, 0, 0, 16'h0100, 1, 0, 0);
    step("dec0059", 0, 0, 0, 0, 16'h0059, 1, 0, 0);

    // Pause / resume
    preset(0, 5, 0, 0);
    step("ld0500", 0, 0, 0, 1, 16'h0059, 1, 0, 0);
    step("ss0500", 0, 0, 1, 0, 16'h0500, 0, 0, 0);
    step("pause_en", 0, 1, 1, 0, 16'h0500, 1, 0, 0);
    for (int k = 1; k <= 3; k++)
      step($sformatf("paused_en%0d", k), 0, 1, 0, 0, 16'h0500, 0, 0, 0);
    step("resume", 0, 0, 1, 0, 16'h0500, 0, 0, 0);
    step("en0500", 0, 1, 0, 0, 16'h0500, 1, 0, 0);
    step("dec0459", 0, 0, 0, 0, 16'h0459, 1, 0, 0);

    // LOAD beats SS and EN; SS masks BR; SS in DONE silences alarm
    preset(0, 0, 0, 1);
    step("ld_ss_en", 0, 1, 1, 1, 16'h0459, 1, 0, 0);
    step("idle_ss_en", 0, 1, 1, 0, 16'h0001, 0, 0, 0);
    step("run0001", 0, 0, 0, 0, 16'h0001, 1, 0, 0);
    step("ss_masks_br", 0, 1, 1, 0, 16'h0001, 1, 0, 0);
    step("resume0001", 0, 0, 1, 0, 16'h0001, 0, 0, 0);
    step("br_again", 0, 1, 0, 0, 16'h0001, 1, 0, 1);
    step("done_ss", 0, 0, 1, 0, 16'h0000, 0, 1, 0);
    step("silenced", 0, 0, 0, 0, 16'h0000, 0, 0, 0);

    // Clamping, start at 00:00, idle ignores EN
    preset(0, 0, 7, 12);
    step("ld_clamp_s", 0, 0, 0, 1, 16'h0000, 0, 0, 0);
    step("clamp0059", 0, 0, 0, 0, 16'h0059, 0, 0, 0);
    preset(0, 0, 0, 0);
    step("ld0000", 0, 0, 0, 1, 16'h0059, 0, 0, 0);
    step("ss_at_zero", 0, 0, 1, 0, 16'h0000, 0, 0, 0);
    step("stay_idle", 0, 0, 0, 0, 16'h0000, 0, 0, 0);
    preset(7, 15, 6, 10);
    step("ld_clamp_all", 0, 0, 0, 1, 16'h0000, 0, 0, 0);
    step("idle_en", 0, 1, 0, 0, 16'h5959, 0, 0, 0);
    step("ss5959", 0, 0, 1, 0, 16'h5959, 0, 0, 0);
    step("en5959", 0, 1, 0, 0, 16'h5959, 1, 0, 0);
    step("dec5958", 0, 0, 0, 0, 16'h5958, 1, 0, 0);

    @(negedge CLK);
    @(negedge CLK);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    drv_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    if (!drv_done) begin
      $display("FAIL timeout: driver did not finish");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/sec_dncnt.md
# sec_dncnt

BCD minutes:seconds countdown timer, 59:59 down to 00:00, for the CLOCK24 family. It counts on the same one-cycle 1 Hz enable used by the up-counting second/minute counters. The block loads a preset time, runs, pauses and resumes under a start/stop pulse, emits a borrow pulse when the count reaches zero, and holds an alarm for a programmable number of ticks. It feeds the shared 7-segment display mux and the buzzer driver.

## Interface
- ALARM_TICKS, default 10: number of EN ticks ALARM stays high after expiry; legal range 1–255.
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  1 Hz tick, one CLK cycle wide.
- SS  in  1  start/stop pulse, one CLK cycle wide.
- LOAD  in  1  load-preset pulse, one CLK cycle wide.
- PSL  in  4  preset seconds, ones digit (BCD).
- PSH  in  3  preset seconds, tens digit.
- PML  in  4  preset minutes, ones digit (BCD).
- PMH  in  3  preset minutes, tens digit.
- SL, SH, ML, MH  out  4/3/4/3  current count digits.
- RUN  out  1  high in state RUN.
- ALARM  out  1  expiry alarm.
- BR  out  1  borrow pulse; high in the cycle the count steps 00:01 to 00:00.

## Operation
- States:
  - IDLE: stopped, count held.
  - RUN: counting.
  - PAUSE: count held.
  - DONE: expired, count 00:00, ALARM high.
- Priority per cycle, highest first: RST, LOAD, SS, EN.
- LOAD, any state:
  - Digits take the preset values.
  - Out-of-range preset digits clamp: PSL/PML >9 become 9; PSH/PMH >5 become 5.
  - State goes to IDLE, ALARM clears, the alarm tick counter clears.
- SS transitions:
  - IDLE: go to RUN if count ≠ 00:00; otherwise stay in IDLE.
  - RUN: go to PAUSE.
  - PAUSE: go to RUN.
  - DONE: go to IDLE (silences ALARM, count stays 00:00).
- EN in RUN with no SS or LOAD in the same cycle decrements the count by one second.
- Decrement cascade:
  - SL 0 wraps to 9 and borrows from SH.
  - SH 0 wraps to 5 and borrows from ML.
  - ML 0 wraps to 9 and borrows from MH.
  - MH never underflows; RUN is never entered at 00:00.
- BR is combinational: BR = RUN state & EN & count==00:01 & !SS & !LOAD.
- At BR the next state is DONE with count 00:00 and ALARM=1.
- DONE: each EN increments the alarm tick counter. When ALARM_TICKS ticks have elapsed, ALARM drops and state goes to IDLE.
- EN in IDLE or PAUSE is ignored.
- Tick counter width is 8 bits.

## Timing
- Reset values: all digits 0, RUN=0, ALARM=0, BR=0 (combinational, follows inputs), state IDLE, tick counter 0. Reset acts immediately, mid-count included.
- Digits, RUN and ALARM are registered and change one CLK after the causing input edge.
- SS and LOAD take effect on the next rising edge.
- SS coincident with EN in RUN: pause, no decrement.
- SS coincident with EN in IDLE or PAUSE: enter RUN, no decrement that cycle.
- LOAD coincident with SS or EN: only LOAD acts.
- ALARM rises the cycle after BR. It falls the cycle after the ALARM_TICKS-th EN in DONE, with RUN=0 at the same edge.

## Configuration
- SEC_DNCNT_AUTORELOAD_EN defined:
  - An internal reload register captures the clamped preset on LOAD.
  - At BR the counter loads the reload value instead of 00:00 and stays in RUN.
  - ALARM runs for ALARM_TICKS EN ticks while counting continues.
  - A BR during an active alarm restarts the tick count.
  - If the reload value is 00:00, behaviour is identical to the undefined case.
- Undefined: no reload register; behaviour exactly as in Operation.

## Test plan
- RST mid-RUN at 03:27 -> all outputs 0, state IDLE on the same edge; next EN causes no change.
- LOAD preset 00:03, SS, 3 EN ticks -> 00:02, 00:01, 00:00; BR high only in the third EN cycle; ALARM=1 next cycle; after 10 further EN ticks ALARM=0, RUN=0.
- LOAD 10:00, SS, one EN -> 09:59; LOAD 01:00, SS, one EN -> 00:59 (borrow through all digits).
- Pause: RUN at 05:00, SS with EN in the same cycle -> PAUSE, count 05:00; 3 EN ticks -> unchanged; SS -> RUN; next EN -> 04:59.
- LOAD with PSL=12, PSH=7 -> SL=9, SH=5; SS at 00:00 -> stays IDLE, RUN=0; SS in DONE -> ALARM=0 next cycle.
- Macro defined, preset 00:02, SS, 2 EN ticks -> BR at the 01-to-00 step, count reloads 00:02, RUN stays 1, ALARM=1 for 10 ticks.
